// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin the op on ALUControl/SrcA/SrcB (ignored while busy)
//   flush        abort any in-flight op, no done pulse, result kept
//   ALUControl   5-bit RV32M op code from decode
//   SrcA, SrcB   rs1 / rs2 operands
//   busy         high while iterating
//   done         one-cycle completion pulse, result valid in the same cycle
//   result       registered result, held until the next completion
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      ALUControl,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [5:0] cnt;
    logic [2*XLEN-1:0] acc, acc_n, prod_s;
    logic [XLEN-1:0] mag_a, mag_b, mag_a_in, mag_b_in, special_res, quo, rem, rem_sub, final_res;
    logic [XLEN:0] sum, sh;
    logic is_div, sel_hi, neg_a, neg_b;
    logic valid, div_op, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in, div_zero, ovf, special, accept, ge;
    // All eight RV32M codes end in 01; bits [4:2] select the op.
    assign valid = ALUControl[1:0] == 2'b01;
    assign div_op = ALUControl[4];
    assign sgn_a_in = div_op ? !ALUControl[2] : ALUControl[3:2] != 2'b10;
    assign sgn_b_in = div_op ? !ALUControl[2] : !ALUControl[3];
    assign neg_a_in = sgn_a_in & SrcA[XLEN-1];
    assign neg_b_in = sgn_b_in & SrcB[XLEN-1];
    assign mag_a_in = neg_a_in ? -SrcA : SrcA;
    assign mag_b_in = neg_b_in ? -SrcB : SrcB;
    assign div_zero = SrcB == '0;
    assign ovf = !ALUControl[2] && SrcA == {1'b1, {(XLEN-1){1'b0}}} && SrcB == '1;
    assign special = div_op && (div_zero || ovf);
    // Overflow DIV returns the dividend itself (most negative value).
    assign special_res = div_zero ? (ALUControl[3] ? SrcA : '1) : (ALUControl[3] ? '0 : SrcA);
    assign accept = start && !flush && state != CALC && valid;
    assign busy = state == CALC;
    assign done = state == DONE;
    // acc holds {partial product} for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge = sh >= {1'b0, mag_b};
        rem_sub = sh[XLEN-1:0] - mag_b;
        acc_n = is_div ? {ge ? rem_sub : sh[XLEN-1:0], acc[XLEN-2:0], ge} : {sum, acc[XLEN-1:1]};
        prod_s = (neg_a ^ neg_b) ? -acc_n : acc_n;
        quo = (neg_a ^ neg_b) ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        rem = neg_a ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
        final_res = is_div ? (sel_hi ? rem : quo) : (sel_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0]);
    end
    always_comb begin
        state_n = state;
        if (flush) state_n = IDLE;
        else if (accept) state_n = special ? DONE : CALC;
        else if (state == CALC) state_n = (cnt == 6'd31) ? DONE : CALC;
        else state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            result <= '0;
            acc <= '0;
            mag_a <= '0;
            mag_b <= '0;
            is_div <= 1'b0;
            sel_hi <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
            is_div <= div_op;
            sel_hi <= div_op ? ALUControl[3] : |ALUControl[3:2];
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            mag_a <= mag_a_in;
            mag_b <= mag_b_in;
            acc <= {{XLEN{1'b0}}, div_op ? mag_a_in : mag_b_in};
            if (special) result <= special_res;
        end else if (state == CALC) begin
            acc <= acc_n;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) result <= final_res;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam logic [4:0] MUL = 5'b00001, MULH = 5'b00101, MULHSU = 5'b01101, MULHU = 5'b01001;
    localparam logic [4:0] DIV = 5'b10001, DIVU = 5'b10101, REM = 5'b11001, REMU = 5'b11101, NOP = 5'b11111;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [4:0] ALUControl = NOP;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic busy, done;
    logic [31:0] result;
    int errors = 0, checks = 0;
    logic [4:0] codes [8] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    logic [4:0] d_op [11] = '{MUL, MULH, MULHSU, MULHU, DIV, REM, DIVU, REMU, DIVU, REM, DIV};
    logic [31:0] d_a [11] = '{32'd7, 32'h80000000, 32'hffffffff, 32'hffffffff, 32'hfffffff9,
                              32'hfffffff9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000};
    logic [31:0] d_b [11] = '{32'hfffffffd, 32'h80000000, 32'hffffffff, 32'hffffffff, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hffffffff};

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            MUL:    begin p = sa * sb; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            DIV:    begin if (b == 0) return 32'hffffffff; p = sa / sb; return p[31:0]; end
            REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            DIVU:   return b == 0 ? 32'hffffffff : a / b;
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {MUL, MULH, MULHSU, MULHU}) return 1'b0;
        return b == 0 || ((op == DIV || op == REM) && a == 32'h80000000 && b == 32'hffffffff);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hffffffff;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, then measure latency, busy cycles and result; returns in the done cycle.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        bit sp;
        int lat, bcyc;
        string tag;
        exp = ref_model(op, a, b);
        sp = is_special(op, a, b);
        tag = $sformatf("op=%b a=%h b=%h", op, a, b);
        ALUControl = op;
        SrcA = a;
        SrcB = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        ALUControl = NOP;
        SrcA = $urandom;
        SrcB = $urandom;
        lat = 1;
        bcyc = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            ALUControl = codes[$urandom_range(0, 7)];
            SrcA = $urandom;
            SrcB = $urandom;
            tick();
            lat++;
        end
        start = 1'b0;
        ALUControl = NOP;
        check({"latency ", tag}, 32'(lat), sp ? 32'd1 : 32'd33);
        check({"busy_cycles ", tag}, 32'(bcyc), sp ? 32'd0 : 32'd32);
        check({"result ", tag}, result, exp);
    endtask

    initial begin
        logic [31:0] old, exp_last;
        int seen;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) do_op(d_op[i], d_a[i], d_b[i]);
        tick();
        check("done one cycle", 32'(done), 32'd0);
        check("result held", result, 32'h80000000);
        old = result;
        ALUControl = DIV;
        SrcA = 32'd1000;
        SrcB = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            if (done) seen++;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result kept", result, old);
        for (int i = 0; i < 30; i++) begin
            if (done) seen++;
            tick();
        end
        check("flush no done pulse", 32'(seen), 32'd0);
        check("flush result still kept", result, old);
        do_op(MUL, 32'd3, 32'd4);
        tick();
        ALUControl = DIV;
        SrcA = 32'd9;
        SrcB = 32'd0;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush beats start busy", 32'(busy), 32'd0);
        check("flush beats start done", 32'(done), 32'd0);
        check("flush beats start result", result, 32'd12);
        ALUControl = NOP;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("nop busy", 32'(busy), 32'd0);
        check("nop done", 32'(done), 32'd0);
        tick();
        check("nop done later", 32'(done), 32'd0);
        ALUControl = MULHU;
        SrcA = 32'hffffffff;
        SrcB = 32'hffffffff;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        do_op(MULHU, 32'hffffffff, 32'hffffffff);
        do_op(REM, 32'hfffffff9, 32'd2);
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            logic [31:0] a, b;
            op = codes[$urandom_range(0, 7)];
            a = pick();
            b = pick();
            exp_last = ref_model(op, a, b);
            do_op(op, a, b);
            if ($urandom_range(0, 2) == 0) begin
                tick();
                check("gap done low", 32'(done), 32'd0);
                check("gap result held", result, exp_last);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
